// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request/ack bus and the decode-side valid/ready bus
// of the fetch unit, plus the decoded instruction fields handed to control.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_instr,
        input  id_ready,
        output opcode, funct3, funct7, rd, rs1, rs2
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_instr,
        output id_ready,
        input  opcode, funct3, funct7, rd, rs1, rs2
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds one instruction
// for decode, and squashes or drains in-flight work when a PC redirect arrives.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                 clock,
    input  logic                 reset,
    instr_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic            imem_req_r;
    logic [XLEN-1:0] imem_addr_r;
    logic            id_valid_r;
    logic [XLEN-1:0] id_pc_r;
    logic [31:0]     id_instr_r;

    logic [XLEN-1:0] redirect_pc_s;

    assign redirect_pc_s = align_pc(bus.redirect_pc);

    // Fetch FSM; imem_addr_r doubles as the pending address while draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
            id_valid_r  <= 1'b0;
            id_pc_r     <= RESET_PC;
            id_instr_r  <= NOP_INSTR;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= FETCH;
                    imem_req_r <= 1'b1;
                    if (bus.redirect_valid) begin
                        pc_r        <= redirect_pc_s;
                        imem_addr_r <= redirect_pc_s;
                    end else begin
                        imem_addr_r <= pc_r;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        pc_r <= redirect_pc_s;
                        if (bus.imem_ack) begin
                            imem_addr_r <= redirect_pc_s;
                        end else begin
                            // Outstanding request to pc_r keeps going until acked.
                            state_r <= DRAIN;
                        end
                    end else if (bus.imem_ack) begin
                        id_instr_r <= bus.imem_rdata;
                        id_pc_r    <= pc_r;
                        pc_r       <= pc_r + PC_STEP;
                        id_valid_r <= 1'b1;
                        imem_req_r <= 1'b0;
                        state_r    <= HOLD;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        state_r     <= FETCH;
                        imem_addr_r <= bus.redirect_valid ? redirect_pc_s : pc_r;
                    end else begin
                        state_r <= DRAIN;
                    end
                    if (bus.redirect_valid) begin
                        pc_r <= redirect_pc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        id_valid_r  <= 1'b0;
                        pc_r        <= redirect_pc_s;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= redirect_pc_s;
                        state_r     <= FETCH;
                    end else if (bus.id_ready) begin
                        id_valid_r  <= 1'b0;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                        state_r     <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    imem_req_r <= 1'b0;
                    id_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_r;
    assign bus.imem_addr = imem_addr_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.id_pc     = id_pc_r;
    assign bus.id_instr  = id_instr_r;

    assign bus.opcode = id_instr_r[6:0];
    assign bus.rd     = id_instr_r[11:7];
    assign bus.funct3 = id_instr_r[14:12];
    assign bus.rs1    = id_instr_r[19:15];
    assign bus.rs2    = id_instr_r[24:20];
    assign bus.funct7 = id_instr_r[31:25];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one vector per clock edge with
// hand-computed expected outputs, plus a bounded hand-written fetch at the end.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h0050_0093; // addi x1, x0, 5
    localparam logic [31:0] I2  = 32'h40B5_0533; // sub  x10, x10, x11

    logic clock;
    logic reset;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(input logic rst, input logic ack, input logic [31:0] rdata,
                                input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = e_instr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        int waited;
        logic [31:0] instr_tmp;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready = 1'b0;

        // rst ack rdata rv rpc rdy | req addr valid id_pc instr
        add(1'b1, 1'b0, I1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, I1);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, I1);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, I1);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h4, I1);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, I1);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, I1);
        add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h8, I1);
        add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, I2);
        // redirect to unaligned 0x103 in HOLD while decode is ready
        add(1'b0, 1'b0, I2, 1'b1, 32'h103, 1'b1, 1'b1, 32'h100, 1'b0, 32'hC, I2);
        add(1'b0, 1'b0, I1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'hC, I2);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, I1);
        // go fetch at 0x8, then redirect to 0x200 with ack delayed three cycles
        add(1'b0, 1'b0, I1, 1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 1'b0, 32'h100, I1);
        add(1'b0, 1'b0, I1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h8, 1'b0, 32'h100, I1);
        add(1'b0, 1'b0, I2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h100, I1);
        add(1'b0, 1'b0, I2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h100, I1);
        add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h100, I1);
        // redirect coincident with ack in FETCH
        add(1'b0, 1'b1, I2, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 1'b0, 32'h100, I1);
        add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, I2);
        // PC wrap at the top of the address space
        add(1'b0, 1'b0, I1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h300, I2);
        add(1'b0, 1'b1, I1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, I1);
        add(1'b0, 1'b0, I1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, I1);
        // DRAIN with a second redirect landing on the same cycle as the ack
        add(1'b0, 1'b0, I1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, I1);
        add(1'b0, 1'b1, I2, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0, 32'hFFFF_FFFC, I1);
        // reset while draining
        add(1'b0, 1'b0, I2, 1'b1, 32'h500, 1'b0, 1'b1, 32'h80, 1'b0, 32'hFFFF_FFFC, I1);
        add(1'b1, 1'b0, I2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        add(1'b0, 1'b0, I2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        add(1'b0, 1'b1, I2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I2);

        for (int i = 0; i < vecs.size(); i++) begin
            reset              = vecs[i].rst;
            bus.imem_ack       = vecs[i].ack;
            bus.imem_rdata     = vecs[i].rdata;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.id_ready       = vecs[i].rdy;
            @(posedge clock);
            #1;
            instr_tmp = vecs[i].e_instr;
            chk("imem_req", i, {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk("imem_addr", i, bus.imem_addr, vecs[i].e_addr);
            chk("id_valid", i, {31'b0, bus.id_valid}, {31'b0, vecs[i].e_valid});
            chk("id_pc", i, bus.id_pc, vecs[i].e_pc);
            chk("id_instr", i, bus.id_instr, instr_tmp);
            chk("opcode", i, {25'b0, bus.opcode}, {25'b0, instr_tmp[6:0]});
            chk("rd", i, {27'b0, bus.rd}, {27'b0, instr_tmp[11:7]});
        end

        // decoded fields of the held sub instruction
        chk("dec_opcode", 100, {25'b0, bus.opcode}, 32'h33);
        chk("dec_rd",     100, {27'b0, bus.rd},     32'd10);
        chk("dec_funct3", 100, {29'b0, bus.funct3}, 32'd0);
        chk("dec_rs1",    100, {27'b0, bus.rs1},    32'd10);
        chk("dec_rs2",    100, {27'b0, bus.rs2},    32'd11);
        chk("dec_funct7", 100, {25'b0, bus.funct7}, 32'h20);

        // hand sequence: accept, then fetch at 0x4 with a slow memory
        bus.imem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("seq_req", 101, {31'b0, bus.imem_req}, 32'd1);
        chk("seq_addr", 101, bus.imem_addr, 32'h4);
        bus.id_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("seq_addr_stable", 102, bus.imem_addr, 32'h4);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = I1;
        waited = 0;
        while (bus.id_valid !== 1'b1 && waited < 8) begin
            @(posedge clock);
            #1;
            waited++;
        end
        bus.imem_ack = 1'b0;
        chk("seq_latency", 103, waited, 32'd1);
        chk("seq_id_pc", 103, bus.id_pc, 32'h4);
        chk("seq_id_instr", 103, bus.id_instr, I1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
